// File: rtl/addsub_arbiter.sv
// Round-robin sequencer that time-shares one external adder/subtractor among NUM_REQ requesters.
// Optional signed-overflow output rsp_ovf is enabled by defining ADDSUB_ARB_OVF_EN.
module addsub_arbiter #(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_m,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_m,
  input  logic [WIDTH-1:0]         add_sum,
  input  logic                     add_cout,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout
`ifdef ADDSUB_ARB_OVF_EN
  ,
  output logic                     rsp_ovf
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] cur_id;
  logic [ID_W-1:0] cand;
  logic [ID_W-1:0] grant_id;
  logic            grant_hit;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_m;

`ifdef ADDSUB_ARB_OVF_EN
  function automatic logic ovf_of(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic [WIDTH-1:0] s, input logic m);
    logic bx_msb;
    bx_msb = b[WIDTH-1] ^ m;
    return (a[WIDTH-1] == bx_msb) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction
`endif

  // Rotating search starting just after the previous winner.
  always_comb begin
    cand      = last_grant;
    grant_id  = '0;
    grant_hit = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == ID_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      if (!grant_hit && req_valid[cand]) begin
        grant_hit = 1'b1;
        grant_id  = cand;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_m = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
        sel_m = req_m[i];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && grant_hit) req_ready[grant_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      cur_id     <= '0;
      add_a      <= '0;
      add_b      <= '0;
      add_m      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
`ifdef ADDSUB_ARB_OVF_EN
      rsp_ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_hit) begin
            add_a      <= sel_a;
            add_b      <= sel_b;
            add_m      <= sel_m;
            cur_id     <= grant_id;
            last_grant <= grant_id;
            state      <= EXEC;
          end
        end
        // Shared adder has had a full cycle to settle on the registered operands.
        EXEC: begin
          rsp_sum   <= add_sum;
          rsp_cout  <= add_cout;
          rsp_id    <= cur_id;
`ifdef ADDSUB_ARB_OVF_EN
          rsp_ovf   <= ovf_of(add_a, add_b, add_sum, add_m);
`endif
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
